// File: rtl/dev_bridge_pkg.sv
// Shared types and constants for the N-channel CPU/peripheral bridge.
package dev_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } bridge_state_t;

  localparam logic [2:0] DM_WORD   = 3'd0;
  localparam logic [2:0] DM_HALF_U = 3'd1;
  localparam logic [2:0] DM_HALF_S = 3'd2;
  localparam logic [2:0] DM_BYTE_U = 3'd3;
  localparam logic [2:0] DM_BYTE_S = 3'd4;

  localparam int HWIRQ_W = 6;

endpackage

// File: rtl/bridge_lane_align.sv
// Combinational byte-lane logic: store-side enables/replication/alignment check
// and load-side lane select with zero/sign extension.
module bridge_lane_align
  import dev_bridge_pkg::*;
(
  input  logic [1:0]  i_wrOfs,
  input  logic [2:0]  i_wrMode,
  input  logic [31:0] i_wrData,
  output logic [3:0]  o_be,
  output logic [31:0] o_wrData,
  output logic        o_alignErr,
  input  logic [1:0]  i_rdOfs,
  input  logic [2:0]  i_rdMode,
  input  logic [31:0] i_rdData,
  output logic [31:0] o_rdData
);

  logic [15:0] w_half;
  logic [7:0]  w_byte;

  always_comb begin
    o_be       = 4'h0;
    o_wrData   = i_wrData;
    o_alignErr = 1'b0;
    case (i_wrMode)
      DM_WORD: begin
        o_be       = 4'hF;
        o_alignErr = (i_wrOfs != 2'b00);
      end
      DM_HALF_U, DM_HALF_S: begin
        o_be       = 4'b0011 << i_wrOfs;
        o_wrData   = {2{i_wrData[15:0]}};
        o_alignErr = i_wrOfs[0];
      end
      DM_BYTE_U, DM_BYTE_S: begin
        o_be     = 4'b0001 << i_wrOfs;
        o_wrData = {4{i_wrData[7:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    w_half = i_rdOfs[1] ? i_rdData[31:16] : i_rdData[15:0];
    case (i_rdOfs)
      2'd0:    w_byte = i_rdData[7:0];
      2'd1:    w_byte = i_rdData[15:8];
      2'd2:    w_byte = i_rdData[23:16];
      default: w_byte = i_rdData[31:24];
    endcase
    case (i_rdMode)
      DM_HALF_U: o_rdData = {16'h0, w_half};
      DM_HALF_S: o_rdData = {{16{w_half[15]}}, w_half};
      DM_BYTE_U: o_rdData = {24'h0, w_byte};
      DM_BYTE_S: o_rdData = {{24{w_byte[7]}}, w_byte};
      default:   o_rdData = i_rdData;
    endcase
  end

endmodule

// File: rtl/dev_bridge_n.sv
// N-channel CPU-to-peripheral bridge: address decode, access FSM, lane alignment, IRQ sync.
// Optional macro BRIDGE_TIMEOUT_EN adds a dead-device timeout in ACCESS.
module dev_bridge_n
  import dev_bridge_pkg::*;
#(
  parameter int                      NUM_DEV  = 6,
  parameter logic [NUM_DEV*32-1:0]   DEV_BASE = {NUM_DEV{32'h0}},
  parameter logic [NUM_DEV*32-1:0]   DEV_MASK = {NUM_DEV{32'hFFFFFFF0}},
  parameter int                      TIMEOUT  = 15
) (
  input  logic                    clk,
  input  logic                    sys_rstn,
  input  logic                    cpu_req,
  input  logic [31:0]             cpu_addr,
  input  logic                    cpu_we,
  input  logic [2:0]              dm_mode,
  input  logic [31:0]             cpu_wdata,
  output logic [31:0]             cpu_rdata,
  output logic                    cpu_ready,
  output logic                    cpu_stop,
  output logic                    bus_err,
  output logic [HWIRQ_W-1:0]      hwirq,
  output logic [NUM_DEV-1:0]      dev_sel,
  output logic                    dev_we,
  output logic [31:0]             dev_addr,
  output logic [3:0]              dev_be,
  output logic [31:0]             dev_wdata,
  input  logic [NUM_DEV*32-1:0]   dev_rdata,
  input  logic [NUM_DEV-1:0]      dev_ack,
  input  logic [NUM_DEV-1:0]      dev_irq
);

  bridge_state_t r_state, w_next;

  logic [31:0]        r_addr, r_wdata, r_rdata;
  logic               r_we, r_err;
  logic [2:0]         r_mode;
  logic [3:0]         r_be, r_chan;
  logic [HWIRQ_W-1:0] r_hwirq;

  logic               w_hit, w_alignErr, w_reqErr, w_selAck, w_timeout;
  logic [3:0]         w_idx, w_be;
  logic [31:0]        w_shWdata, w_selData, w_extData;
  logic [NUM_DEV-1:0] w_sel;
  logic [15:0]        w_irqPad;
  logic [HWIRQ_W-1:0] w_irq;

  // Descending scan so the lowest matching channel wins on overlapping windows.
  always_comb begin
    w_hit = 1'b0;
    w_idx = 4'd0;
    for (int i = NUM_DEV - 1; i >= 0; i--) begin
      if ((cpu_addr & DEV_MASK[32*i +: 32]) == DEV_BASE[32*i +: 32]) begin
        w_hit = 1'b1;
        w_idx = 4'(i);
      end
    end
  end

  always_comb begin
    w_sel     = '0;
    w_selData = 32'h0;
    w_selAck  = 1'b0;
    for (int i = 0; i < NUM_DEV; i++) begin
      if (r_chan == 4'(i)) begin
        w_sel[i]  = 1'b1;
        w_selData = dev_rdata[32*i +: 32];
        w_selAck  = dev_ack[i];
      end
    end
  end

  bridge_lane_align u_align (
    .i_wrOfs    (cpu_addr[1:0]),
    .i_wrMode   (dm_mode),
    .i_wrData   (cpu_wdata),
    .o_be       (w_be),
    .o_wrData   (w_shWdata),
    .o_alignErr (w_alignErr),
    .i_rdOfs    (r_addr[1:0]),
    .i_rdMode   (r_mode),
    .i_rdData   (w_selData),
    .o_rdData   (w_extData)
  );

  assign w_reqErr = !w_hit || w_alignErr || (dm_mode > DM_BYTE_S);

`ifdef BRIDGE_TIMEOUT_EN
  logic [7:0] r_cnt;

  assign w_timeout = (r_cnt == 8'(TIMEOUT));

  always_ff @(posedge clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      r_cnt <= 8'd0;
    end else if (r_state == ST_IDLE) begin
      r_cnt <= 8'd0;
    end else if (r_state == ST_ACCESS && !w_selAck && !w_timeout) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge sys_rstn) begin
    if (!sys_rstn) r_state <= ST_IDLE;
    else           r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (cpu_req) w_next = w_reqErr ? ST_DONE : ST_ACCESS;
      ST_ACCESS: if (w_selAck || w_timeout) w_next = ST_DONE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Request fields are latched only for accesses that actually reach a device.
  always_ff @(posedge clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
      r_rdata <= 32'h0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_mode  <= DM_WORD;
      r_be    <= 4'h0;
      r_chan  <= 4'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cpu_req) begin
            r_err   <= w_reqErr;
            r_rdata <= 32'h0;
            if (!w_reqErr) begin
              r_addr  <= cpu_addr;
              r_wdata <= w_shWdata;
              r_we    <= cpu_we;
              r_mode  <= dm_mode;
              r_be    <= w_be;
              r_chan  <= w_idx;
            end
          end
        end
        ST_ACCESS: begin
          if (w_selAck) begin
            r_rdata <= r_we ? 32'h0 : w_extData;
            r_err   <= 1'b0;
          end else if (w_timeout) begin
            r_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Channels beyond the sixth share the top CPU interrupt line.
  always_comb begin
    w_irqPad                 = 16'(dev_irq);
    w_irq                    = w_irqPad[HWIRQ_W-1:0];
    w_irq[HWIRQ_W-1]         = w_irqPad[HWIRQ_W-1] | (|w_irqPad[15:HWIRQ_W]);
  end

  always_ff @(posedge clk or negedge sys_rstn) begin
    if (!sys_rstn) r_hwirq <= '0;
    else           r_hwirq <= w_irq;
  end

  assign hwirq     = r_hwirq;
  assign dev_sel   = (r_state == ST_ACCESS) ? w_sel : '0;
  assign dev_we    = (r_state == ST_ACCESS) && r_we;
  assign dev_be    = (r_state == ST_ACCESS) ? r_be : 4'h0;
  assign dev_addr  = r_addr;
  assign dev_wdata = r_wdata;
  assign cpu_ready = (r_state == ST_DONE);
  assign bus_err   = (r_state == ST_DONE) && r_err;
  assign cpu_rdata = (r_state == ST_DONE) ? r_rdata : 32'h0;
  assign cpu_stop  = ((r_state == ST_IDLE) && cpu_req) || (r_state == ST_ACCESS);

endmodule

// File: tb/tb_dev_bridge_n.sv
// Scoreboard bench for dev_bridge_n with two channels at 0x7F00 / 0x7F10.
module tb_dev_bridge_n;

  logic        clk;
  logic        sys_rstn;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic        cpu_we;
  logic [2:0]  dm_mode;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        cpu_stop;
  logic        bus_err;
  logic [5:0]  hwirq;
  logic [1:0]  dev_sel;
  logic        dev_we;
  logic [31:0] dev_addr;
  logic [3:0]  dev_be;
  logic [31:0] dev_wdata;
  logic [63:0] dev_rdata;
  logic [1:0]  dev_ack;
  logic [1:0]  dev_irq;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          issue;
  } exp_t;

  exp_t expQ[$];
  int   cycleCnt    = 0;
  int   nResp       = 0;
  int   nCompared   = 0;
  int   nMismatched = 0;

  dev_bridge_n #(
    .NUM_DEV  (2),
    .DEV_BASE ({32'h0000_7F10, 32'h0000_7F00}),
    .DEV_MASK ({2{32'hFFFF_FFF0}}),
    .TIMEOUT  (3)
  ) dut (
    .clk       (clk),
    .sys_rstn  (sys_rstn),
    .cpu_req   (cpu_req),
    .cpu_addr  (cpu_addr),
    .cpu_we    (cpu_we),
    .dm_mode   (dm_mode),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ready (cpu_ready),
    .cpu_stop  (cpu_stop),
    .bus_err   (bus_err),
    .hwirq     (hwirq),
    .dev_sel   (dev_sel),
    .dev_we    (dev_we),
    .dev_addr  (dev_addr),
    .dev_be    (dev_be),
    .dev_wdata (dev_wdata),
    .dev_rdata (dev_rdata),
    .dev_ack   (dev_ack),
    .dev_irq   (dev_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt++;

  // Monitor: every completion pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (sys_rstn && cpu_ready) begin
      if (expQ.size() == 0) begin
        nCompared++;
        nMismatched++;
        $display("[TB] FAIL unexpectedReady: got cpu_ready=1 at cycle %0d, expected no completion", cycleCnt);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        nCompared++;
        if (cpu_rdata !== e.rdata) begin
          nMismatched++;
          $display("[TB] FAIL rdata: got %h, expected %h", cpu_rdata, e.rdata);
        end
        nCompared++;
        if (bus_err !== e.err) begin
          nMismatched++;
          $display("[TB] FAIL busErr: got %b, expected %b", bus_err, e.err);
        end
        nCompared++;
        if (cycleCnt - e.issue != e.lat) begin
          nMismatched++;
          $display("[TB] FAIL latency: got %0d, expected %0d", cycleCnt - e.issue, e.lat);
        end
      end
      nResp++;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Issues one access in cycle 0, checks the strobes in cycle 1, then plays the
  // device: ack after ackWait extra cycles (negative = never), optional stray ack
  // on the other channel while waiting.
  task automatic applyStimulus(
    input logic [31:0] addr, input logic we, input logic [2:0] mode,
    input logic [31:0] wdata, input int ackWait, input bit noise,
    input logic [1:0] expSel, input logic [3:0] expBe, input logic [31:0] expWdata,
    input logic [31:0] expRdata, input logic expErr, input int expLat);
    int startResp;
    @(posedge clk); #1;
    cpu_req   = 1'b1;
    cpu_addr  = addr;
    cpu_we    = we;
    dm_mode   = mode;
    cpu_wdata = wdata;
    expQ.push_back('{expRdata, expErr, expLat, cycleCnt});
    startResp = nResp;
    @(negedge clk);
    checkOutput("stopIdle", 32'(cpu_stop), 32'h1);
    @(posedge clk); #1;
    cpu_req = 1'b0;
    @(negedge clk);
    checkOutput("devSel", 32'(dev_sel), 32'(expSel));
    checkOutput("devBe", 32'(dev_be), 32'(expBe));
    if (!expErr) begin
      checkOutput("devWe", 32'(dev_we), 32'(we));
      checkOutput("devWdata", dev_wdata, expWdata);
      checkOutput("devAddr", dev_addr, addr);
      checkOutput("stopAccess", 32'(cpu_stop), 32'h1);
      if (noise) dev_ack = ~expSel;
      if (ackWait >= 0) begin
        repeat (ackWait) begin @(posedge clk); #1; end
        dev_ack = expSel;
        @(posedge clk); #1;
        dev_ack = 2'b00;
      end
    end
    for (int i = 0; i < 80 && nResp == startResp; i++) @(negedge clk);
    dev_ack = 2'b00;
    if (nResp == startResp) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL noReady: got no cpu_ready within 80 cycles, expected one at latency %0d", expLat);
      expQ = {};
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got simulation still running, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    sys_rstn  = 1'b0;
    cpu_req   = 1'b0;
    cpu_addr  = 32'h0;
    cpu_we    = 1'b0;
    dm_mode   = 3'd0;
    cpu_wdata = 32'h0;
    dev_rdata = {32'hDEAD_BEEF, 32'h8011_2233};
    dev_ack   = 2'b00;
    dev_irq   = 2'b00;

    #2;
    checkOutput("rstReady", 32'(cpu_ready), 32'h0);
    checkOutput("rstRdata", cpu_rdata, 32'h0);
    checkOutput("rstSel", 32'(dev_sel), 32'h0);
    checkOutput("rstBe", 32'(dev_be), 32'h0);
    checkOutput("rstHwirq", 32'(hwirq), 32'h0);
    checkOutput("rstBusErr", 32'(bus_err), 32'h0);
    #10 sys_rstn = 1'b1;

    $display("[TB] word load, channel 1, ack in first ACCESS cycle");
    applyStimulus(32'h7F14, 1'b0, 3'd0, 32'h0, 0, 1'b0, 2'b10, 4'hF, 32'h0, 32'hDEAD_BEEF, 1'b0, 2);
    $display("[TB] byte loads at 0x7F03");
    applyStimulus(32'h7F03, 1'b0, 3'd4, 32'h0, 0, 1'b0, 2'b01, 4'b1000, 32'h0, 32'hFFFF_FF80, 1'b0, 2);
    applyStimulus(32'h7F03, 1'b0, 3'd3, 32'h0, 0, 1'b0, 2'b01, 4'b1000, 32'h0, 32'h0000_0080, 1'b0, 2);
    $display("[TB] half store with one wait cycle");
    applyStimulus(32'h7F02, 1'b1, 3'd1, 32'h0000_ABCD, 1, 1'b0, 2'b01, 4'b1100, 32'hABCD_ABCD, 32'h0, 1'b0, 3);
    $display("[TB] signed half load, upper lane, stray acks on channel 0");
    applyStimulus(32'h7F12, 1'b0, 3'd2, 32'h0, 2, 1'b1, 2'b10, 4'b1100, 32'h0, 32'hFFFF_DEAD, 1'b0, 4);
    $display("[TB] error paths");
    applyStimulus(32'h8000, 1'b0, 3'd0, 32'h0, 0, 1'b0, 2'b00, 4'h0, 32'h0, 32'h0, 1'b1, 1);
    applyStimulus(32'h7F01, 1'b0, 3'd0, 32'h0, 0, 1'b0, 2'b00, 4'h0, 32'h0, 32'h0, 1'b1, 1);
    applyStimulus(32'h7F00, 1'b0, 3'd5, 32'h0, 0, 1'b0, 2'b00, 4'h0, 32'h0, 32'h0, 1'b1, 1);

`ifdef BRIDGE_TIMEOUT_EN
    $display("[TB] timeout: dead device, then ack on the boundary cycle");
    applyStimulus(32'h7F00, 1'b0, 3'd0, 32'h0, -1, 1'b1, 2'b01, 4'hF, 32'h0, 32'h0, 1'b1, 5);
    applyStimulus(32'h7F00, 1'b0, 3'd0, 32'h0, 3, 1'b0, 2'b01, 4'hF, 32'h0, 32'h8011_2233, 1'b0, 5);
`else
    $display("[TB] slow device: ack in cycle 20 with stray acks on channel 1");
    applyStimulus(32'h7F00, 1'b0, 3'd0, 32'h0, 19, 1'b1, 2'b01, 4'hF, 32'h0, 32'h8011_2233, 1'b0, 21);
`endif

    $display("[TB] interrupt registration");
    @(posedge clk); #1;
    dev_irq = 2'b01;
    @(negedge clk);
    checkOutput("hwirqLag", 32'(hwirq), 32'h0);
    @(posedge clk); #1;
    dev_irq = 2'b10;
    @(negedge clk);
    checkOutput("hwirqCh0", 32'(hwirq), 32'h01);
    @(negedge clk);
    checkOutput("hwirqCh1", 32'(hwirq), 32'h02);
    dev_irq = 2'b00;

    $display("[TB] reset asserted during ACCESS");
    @(posedge clk); #1;
    cpu_req  = 1'b1;
    cpu_addr = 32'h7F00;
    cpu_we   = 1'b0;
    dm_mode  = 3'd0;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    @(negedge clk);
    checkOutput("abortSel", 32'(dev_sel), 32'h1);
    @(posedge clk); #1;
    sys_rstn = 1'b0;
    #1;
    checkOutput("abortSelOff", 32'(dev_sel), 32'h0);
    checkOutput("abortStop", 32'(cpu_stop), 32'h0);
    checkOutput("abortReady", 32'(cpu_ready), 32'h0);
    checkOutput("abortBe", 32'(dev_be), 32'h0);
    checkOutput("abortAddr", dev_addr, 32'h0);
    dev_ack = 2'b01;
    repeat (2) @(negedge clk);
    sys_rstn = 1'b1;
    dev_ack  = 2'b00;
    repeat (5) @(negedge clk);
    checkOutput("abortIdle", 32'(cpu_stop), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/dev_bridge_n.md
# dev_bridge_n

Parametrised N-channel system bridge between the CPU data port and memory-mapped peripherals, replacing the fixed six-device bridge. It decodes a programmable address map and runs a per-access handshake FSM that tolerates multi-cycle devices and times out on dead ones. It also aligns sub-word loads and stores, and registers device interrupts onto the CPU `hwirq` lines. It sits between `cpu` and the peripheral instances in `mips`.

## Interface
- `NUM_DEV`, 6: number of device channels, 1..16.
- `DEV_BASE`, {NUM_DEV{32'h0}}: packed NUM_DEV×32 base addresses; channel i is bits [32i+31:32i].
- `DEV_MASK`, {NUM_DEV{32'hFFFFFFF0}}: packed NUM_DEV×32 decode masks. Channel i hits when `(addr & mask_i) == base_i`.
- `TIMEOUT`, 15: maximum cycles spent in ACCESS before a bus error, 1..255.

Ports:
- `clk` in 1: clock; all state changes on rising edge.
- `sys_rstn` in 1: asynchronous, active-low reset.
- `cpu_req` in 1: access request; sampled in IDLE.
- `cpu_addr` in 32: byte address.
- `cpu_we` in 1: 1 = store, 0 = load.
- `dm_mode` in 3: access width and sign; 0 word, 1 half unsigned, 2 half signed, 3 byte unsigned, 4 byte signed; 5..7 are illegal.
- `cpu_wdata` in 32: store data, right-justified.
- `cpu_rdata` out 32: load result, extended per `dm_mode`.
- `cpu_ready` out 1: one-cycle completion pulse.
- `cpu_stop` out 1: stall the CPU pipeline.
- `bus_err` out 1: qualifies `cpu_ready` as a failed access.
- `hwirq` out 6: registered interrupt lines to the CPU (`hwirq[7:2]` in the CPU).
- `dev_sel` out NUM_DEV: one-hot channel strobe.
- `dev_we` out 1: write strobe, shared by all channels.
- `dev_addr` out 32: latched address, shared.
- `dev_be` out 4: byte enables, shared.
- `dev_wdata` out 32: lane-shifted store data, shared.
- `dev_rdata` in NUM_DEV×32: per-channel read data.
- `dev_ack` in NUM_DEV: per-channel completion.
- `dev_irq` in NUM_DEV: per-channel interrupt level.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE → ACCESS when `cpu_req` is high, the decode hits, and the access is aligned. Latch addr, we, mode, lane-shifted wdata, be and channel index.
- IDLE → DONE with error when `cpu_req` is high and any of these holds:
  - no window matches;
  - misaligned access (half with addr[0]=1, word with addr[1:0]≠0);
  - `dm_mode` > 4.
- In the error path no `dev_sel` is ever asserted.
- Overlapping windows: the lowest channel index wins.
- ACCESS:
  - `dev_sel[i]` and `dev_we` are held stable.
  - `dev_ack[i]` from the selected channel → DONE, latch the extended `dev_rdata[i]`.
  - Acks from unselected channels are ignored.
  - The ack may arrive in the first ACCESS cycle.
- DONE:
  - `cpu_ready` = 1 for exactly one cycle, then → IDLE.
  - `cpu_rdata` is valid only in DONE; it is 0 for stores and for errors.
- `cpu_stop` = 1 when (IDLE and `cpu_req`) or ACCESS; it is 0 in DONE.
- `cpu_req` is ignored outside IDLE.
- Byte enables: byte = 1<<addr[1:0]; half = 4'b0011<<addr[1:0]; word = 4'hF.
- Store data is replicated into the lane(s) selected by addr[1:0].
- Load extension selects the addressed lane, then zero- or sign-extends to 32 bits.
- `hwirq[k]` is registered from `dev_irq[k]` for k < min(NUM_DEV,6). `hwirq[5]` additionally ORs `dev_irq[6..NUM_DEV-1]`. Unused bits are 0.

## Timing
- Reset (async assert, sync-safe deassert): state IDLE; all outputs 0, including `hwirq`, `dev_sel`, `dev_be` and `cpu_rdata`. Timeout counter 0.
- Asserting reset mid-access aborts the access with no `cpu_ready`.
- Minimum latency: `cpu_req` in cycle 0 → `dev_sel` in cycle 1 → `cpu_ready` in cycle 2 when the ack arrives in cycle 1.
- Each extra device wait cycle adds one cycle.
- Error path: `cpu_req` in cycle 0 → `cpu_ready`+`bus_err` in cycle 1.
- Timeout: counter clears on entry to ACCESS and increments each ACCESS cycle without an ack.
  - When it reaches `TIMEOUT` → DONE with `bus_err`.
  - An ack in the same cycle the count reaches `TIMEOUT` wins: normal completion.
- `hwirq` lags `dev_irq` by one cycle.

## Configuration
- `BRIDGE_TIMEOUT_EN`:
  - Defined: timeout counter and behaviour as above.
  - Undefined: no counter; ACCESS waits indefinitely for the ack, and `bus_err` is raised only by decode/alignment/mode errors. `TIMEOUT` is then unused.

## Structure
- Package `dev_bridge_pkg` holds:
  - state enum `bridge_state_t`;
  - `dm_mode` encodings `DM_WORD`, `DM_HALF_U`, `DM_HALF_S`, `DM_BYTE_U`, `DM_BYTE_S`;
  - `HWIRQ_W` = 6.
- Sub-module `bridge_lane_align` (purely combinational) computes `dev_be`, shifted write data, the alignment-error flag and the extended read data.
- Decode, FSM, timeout counter and IRQ registers live in the top module.

## Test plan
- NUM_DEV=2, bases 0x7F00/0x7F10, mask 0xFFFFFFF0. Word load at 0x7F14 with ack in first ACCESS cycle, `dev_rdata[1]`=0xDEADBEEF → `dev_sel`=2'b10 at cycle 1; `cpu_ready` at cycle 2 with 0xDEADBEEF and `bus_err`=0.
- Signed-byte load at 0x7F03, `dev_rdata[0]`=0x80112233 → `dev_be`=4'b1000, `cpu_rdata`=0xFFFFFF80. The unsigned variant gives 0x00000080.
- Half store at 0x7F02 with data 0x0000ABCD → `dev_be`=4'b1100, `dev_wdata`[31:16]=0xABCD, `dev_we`=1.
- Load at unmapped 0x8000, and word load at 0x7F01 → `cpu_ready`+`bus_err` at cycle 1, `dev_sel` never asserted, `cpu_rdata`=0.
- TIMEOUT=3 with the device never acking → `bus_err` at cycle 5. With `BRIDGE_TIMEOUT_EN` undefined, the access stalls until an ack at cycle 20.
- `dev_irq`=2'b01 → `hwirq`=6'b000001 one cycle later. Pulling `sys_rstn` low during ACCESS → outputs 0 immediately and no `cpu_ready`.
